video_bus_bridge: RTL and testbench
===================================

# video_bus_bridge

CPU-side bridge directly upstream of the VGA scanout stage. It accepts CPU memory and I/O write strobes, maps writes into the 6912-byte video RAM through a small write FIFO, and runs a hardware screen-fill engine. It also holds the border/beeper port register, generates the frame interrupt from vertical sync, and produces the attribute flash phase consumed by the scanout path.

## Interface
- FIFO_DEPTH, 4: CPU write FIFO entries (power of two, ≥2)
- IRQ_LEN, 32: frame interrupt pulse length in clocks
- VBASE, 16'h4000: CPU address mapped to video RAM address 0
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_a  in  16  CPU address
- cpu_d  in  8  CPU write data
- cpu_mw  in  1  memory write strobe, one clock per write
- cpu_iow  in  1  I/O write strobe, one clock per write
- cpu_wait  out  1  FIFO full; strobes are ignored while high
- vram_a  out  13  video RAM write address (registered)
- vram_d  out  8  video RAM write data (registered)
- vram_we  out  1  video RAM write enable (registered)
- border  out  3  border colour {r,g,b} for scanout
- beeper  out  1  speaker bit
- vs  in  1  vertical sync from scanout, low during sync
- irq  out  1  frame interrupt, active-high
- flash  out  1  attribute flash phase

## Operation
- Memory writes: cpu_mw with VBASE ≤ cpu_a < VBASE+6912 pushes {cpu_a−VBASE, cpu_d} into the FIFO. Any other address is ignored.
- cpu_wait = (count == FIFO_DEPTH). A strobe while cpu_wait is high is dropped; the CPU is responsible for stalling. A push and a pop in the same cycle are legal when the FIFO is not full.
- I/O decode uses cpu_a[7:0] only:
  - 0xFE: border ← cpu_d[2:0], beeper ← cpu_d[4]
  - 0xFD: fill_attr ← cpu_d
  - 0xFC: cpu_d[0]=1 requests a fill
- Only one video RAM write per clock. vram_we is low in any cycle with no write.
- FSM states:
  - IDLE: pops the FIFO head to vram_* when non-empty. A fill request goes to DRAIN.
  - DRAIN: pops the FIFO until empty, then goes to FILL_PIX with addr=0. New CPU writes keep queuing behind the fill.
  - FILL_PIX: writes data 0x00 at addr 0x0000..0x17FF, one per clock. After 0x17FF it goes to FILL_ATR.
  - FILL_ATR: writes fill_attr at 0x1800..0x1AFF. After 0x1AFF it goes to IDLE. The FIFO is not popped during FILL states.
- A fill request while not in IDLE is ignored. fill_attr is sampled when entering FILL_ATR.
- Frame: vs is registered. A falling edge (1→0) loads the irq counter with IRQ_LEN and increments the 4-bit frame counter. irq is high while the counter is non-zero. A new edge while irq is high reloads the counter.
- flash toggles when the frame counter wraps 15→0, i.e. every 16 frames.

## Timing
- Reset values: vram_we=0, vram_a=0, vram_d=0, border=0, beeper=0, irq=0, flash=0, cpu_wait=0. FIFO is empty, state is IDLE, frame counter=0, fill_attr=0x38.
- Reset mid-fill or with a non-empty FIFO aborts all pending work. vram_we is low from the cycle after reset is sampled.
- Write latency in IDLE with an empty FIFO: a strobe sampled at edge k gives vram_we high between edges k+1 and k+2. Back-to-back strobes give back-to-back writes with no bubble.
- I/O register updates are visible after the sampling edge (1 clock).
- Fill with an empty FIFO: request at edge k puts addr 0x0000 on vram_* after edge k+1. DRAIN lasts 0 cycles when the FIFO is empty.
- A fill issues exactly 6912 consecutive writes. The first IDLE pop occurs the cycle after the 0x1AFF write.
- irq rises 2 clocks after vs falls (input register + counter) and stays high exactly IRQ_LEN clocks.

## Test plan
- Write: cpu_mw at cpu_a=0x4000 d=0xAA, then 0x5AFF d=0x55 on the next clock. Expect vram writes (0x0000,0xAA) then (0x1AFF,0x55) on consecutive cycles. A write to 0x5B00 or 0x3FFF produces no vram_we.
- FIFO full: start a fill, then issue 5 writes. Expect cpu_wait high after the 4th, the 5th dropped, and after 6912 fill writes exactly the 4 queued writes committed in order.
- Fill ordering: queue 2 writes, then fill with fill_attr=0x47. Expect the 2 writes first, then 6144×0x00 and 768×0x47, ending at 0x1AFF. A second fill request mid-fill is ignored.
- Port: cpu_iow a=0x00FE d=0x15. Expect border=3'b101 and beeper=1 next cycle. a=0x12FE decodes identically.
- Frame: 32 vs falling edges. Expect 32 irq pulses each exactly IRQ_LEN long, and flash toggling after the 16th and 32nd edges.
- Reset during FILL_PIX at addr 0x0100. Expect vram_we=0 next cycle, FIFO empty, and a subsequent write serviced with 2-cycle latency.

Source files
------------

// File: rtl/video_bus_bridge.sv
// rtl/video_bus_bridge.sv - CPU write bridge into video RAM with fill engine, port register and frame timing
// Feeds the VGA scanout stage: vram writes, border/beeper, frame irq and flash phase.
module video_bus_bridge #(
   parameter int          FIFO_DEPTH = 4,
   parameter int          IRQ_LEN    = 32,
   parameter logic [15:0] VBASE      = 16'h4000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d,
   input  logic        cpu_mw,
   input  logic        cpu_iow,
   output logic        cpu_wait,
   output logic [12:0] vram_a,
   output logic [7:0]  vram_d,
   output logic        vram_we,
   output logic [2:0]  border,
   output logic        beeper,
   input  logic        vs,
   output logic        irq,
   output logic        flash
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = $clog2(IRQ_LEN + 1);
   localparam logic [12:0] PIX_LAST = 13'h17FF;
   localparam logic [12:0] ATR_LAST = 13'h1AFF;

   typedef enum logic [1:0] {IDLE, DRAIN, FILL_PIX, FILL_ATR} state_t;
   state_t state, state_nx;

   logic [20:0]   mem [FIFO_DEPTH];
   logic [20:0]   head;
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count, count_nx;
   logic [CW-1:0] drain_left, drain_left_nx;
   logic [12:0]   fill_addr, fill_addr_nx;
   logic [7:0]    fill_attr, attr_latch;
   logic          attr_load;

   logic [16:0]   a_ext;
   logic [12:0]   a_off;
   logic          in_range, push, pop, io_ok, fill_req;
   logic          wr_en;
   logic [12:0]   wr_a;
   logic [7:0]    wr_d;

   assign a_ext    = {1'b0, cpu_a};
   assign in_range = (a_ext >= {1'b0, VBASE}) && (a_ext < ({1'b0, VBASE} + 17'd6912));
   // In-range offsets are below 8192, so 13-bit modular subtraction is exact.
   assign a_off    = cpu_a[12:0] - VBASE[12:0];

   assign cpu_wait = (count == CW'(FIFO_DEPTH));
   assign push     = cpu_mw && in_range && !cpu_wait;
   assign io_ok    = cpu_iow && !cpu_wait;
   assign fill_req = io_ok && (cpu_a[7:0] == 8'hFC) && cpu_d[0];
   assign pop      = ((state == IDLE) || (state == DRAIN)) && (count != '0);
   assign count_nx = count + CW'(push) - CW'(pop);
   assign head     = mem[rptr];

   always_comb begin
      state_nx      = state;
      wr_en         = 1'b0;
      wr_a          = fill_addr;
      wr_d          = 8'h00;
      fill_addr_nx  = fill_addr;
      drain_left_nx = drain_left;
      attr_load     = 1'b0;
      case (state)
         IDLE: begin
            if (pop) begin
               wr_en = 1'b1;
               wr_a  = head[20:8];
               wr_d  = head[7:0];
            end
            // Only entries queued up to the request are drained ahead of the fill.
            if (fill_req) begin
               drain_left_nx = count_nx;
               fill_addr_nx  = 13'h0000;
               state_nx      = (count_nx == '0) ? FILL_PIX : DRAIN;
            end
         end
         DRAIN: begin
            wr_en         = 1'b1;
            wr_a          = head[20:8];
            wr_d          = head[7:0];
            drain_left_nx = drain_left - 1'b1;
            if (drain_left == CW'(1)) begin
               state_nx     = FILL_PIX;
               fill_addr_nx = 13'h0000;
            end
         end
         FILL_PIX: begin
            wr_en        = 1'b1;
            wr_d         = 8'h00;
            fill_addr_nx = fill_addr + 1'b1;
            if (fill_addr == PIX_LAST) begin
               state_nx  = FILL_ATR;
               attr_load = 1'b1;
            end
         end
         FILL_ATR: begin
            wr_en        = 1'b1;
            wr_d         = attr_latch;
            fill_addr_nx = fill_addr + 1'b1;
            if (fill_addr == ATR_LAST) state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         drain_left <= '0;
         fill_addr  <= '0;
         fill_attr  <= 8'h38;
         attr_latch <= 8'h38;
         border     <= 3'b000;
         beeper     <= 1'b0;
         vram_we    <= 1'b0;
         vram_a     <= '0;
         vram_d     <= '0;
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         drain_left <= drain_left_nx;
         fill_addr  <= fill_addr_nx;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (attr_load) attr_latch <= fill_attr;
         vram_we <= wr_en;
         if (wr_en) begin
            vram_a <= wr_a;
            vram_d <= wr_d;
         end
         if (io_ok && (cpu_a[7:0] == 8'hFE)) begin
            border <= cpu_d[2:0];
            beeper <= cpu_d[4];
         end
         if (io_ok && (cpu_a[7:0] == 8'hFD)) fill_attr <= cpu_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wptr] <= {a_off, cpu_d};
   end

   logic          vs_r, vs_rr, vs_fall;
   logic [IW-1:0] irq_cnt;
   logic [3:0]    frame_cnt;

   // Both sync flops reset low so a sync already low at reset is not taken as an edge.
   assign vs_fall = vs_rr && !vs_r;
   assign irq     = (irq_cnt != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         vs_r      <= 1'b0;
         vs_rr     <= 1'b0;
         irq_cnt   <= '0;
         frame_cnt <= 4'h0;
         flash     <= 1'b0;
      end else begin
         vs_r  <= vs;
         vs_rr <= vs_r;
         if (vs_fall) begin
            irq_cnt   <= IW'(IRQ_LEN);
            frame_cnt <= frame_cnt + 1'b1;
            if (frame_cnt == 4'hF) flash <= !flash;
         end else if (irq_cnt != '0) begin
            irq_cnt <= irq_cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_video_bus_bridge.sv
// tb/tb_video_bus_bridge.sv - self-checking bench for video_bus_bridge
// Cycle reference model built from queues and fill positions, plus directed and random stimulus.
module tb_video_bus_bridge;
   localparam int DEPTH   = 4;
   localparam int IRQ_LEN = 32;

   logic        clock = 1'b0;
   logic        reset, cpu_mw, cpu_iow, vs;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_d;
   logic        cpu_wait, vram_we, beeper, irq, flash;
   logic [12:0] vram_a;
   logic [7:0]  vram_d;
   logic [2:0]  border;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   video_bus_bridge dut (
      .clock(clock), .reset(reset), .cpu_a(cpu_a), .cpu_d(cpu_d),
      .cpu_mw(cpu_mw), .cpu_iow(cpu_iow), .cpu_wait(cpu_wait),
      .vram_a(vram_a), .vram_d(vram_d), .vram_we(vram_we),
      .border(border), .beeper(beeper), .vs(vs), .irq(irq), .flash(flash)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model state
   logic [20:0] q[$];
   int          fill_pos;
   int          drain_n;
   bit          draining;
   logic [7:0]  m_attr, m_latch;
   logic [2:0]  m_border;
   logic        m_beeper;
   logic        e_we;
   logic [12:0] e_a;
   logic [7:0]  e_d;
   logic        v1, v2;
   int          m_irq, m_frames;
   logic        m_flash;

   task automatic model_edge();
      logic full, idle, push, fill_req, fall;
      logic [15:0] off;
      logic [20:0] h;
      if (reset) begin
         q.delete();
         fill_pos = -1; drain_n = 0; draining = 0;
         m_attr = 8'h38; m_latch = 8'h38; m_border = 3'b000; m_beeper = 1'b0;
         e_we = 1'b0; e_a = 13'h0; e_d = 8'h0;
         v1 = 1'b0; v2 = 1'b0; m_irq = 0; m_frames = 0; m_flash = 1'b0;
      end else begin
         full     = (q.size() == DEPTH);
         idle     = (fill_pos < 0) && !draining;
         push     = cpu_mw && !full && (cpu_a >= 16'h4000) && (cpu_a < 16'h5B00);
         fill_req = cpu_iow && !full && (cpu_a[7:0] == 8'hFC) && cpu_d[0] && idle;
         e_we = 1'b0;
         if (fill_pos >= 0) begin
            e_we = 1'b1;
            e_a  = 13'(fill_pos);
            e_d  = (fill_pos < 6144) ? 8'h00 : m_latch;
            if (fill_pos == 6143) m_latch = m_attr;
            fill_pos++;
            if (fill_pos == 6912) fill_pos = -1;
         end else if (q.size() > 0) begin
            h    = q.pop_front();
            e_we = 1'b1;
            e_a  = h[20:8];
            e_d  = h[7:0];
            if (draining) begin
               drain_n--;
               if (drain_n == 0) begin draining = 0; fill_pos = 0; end
            end
         end
         if (push) begin
            off = cpu_a - 16'h4000;
            q.push_back({off[12:0], cpu_d});
         end
         if (fill_req) begin
            if (q.size() == 0) fill_pos = 0;
            else begin draining = 1; drain_n = q.size(); end
         end
         if (cpu_iow && !full && cpu_a[7:0] == 8'hFE) begin
            m_border = cpu_d[2:0]; m_beeper = cpu_d[4];
         end
         if (cpu_iow && !full && cpu_a[7:0] == 8'hFD) m_attr = cpu_d;
         fall = v2 && !v1;
         v2 = v1; v1 = vs;
         if (fall) begin
            m_irq = IRQ_LEN;
            m_frames = (m_frames + 1) % 16;
            if (m_frames == 0) m_flash = !m_flash;
         end else if (m_irq > 0) m_irq--;
      end
   endtask

   function automatic bit busy();
      return (fill_pos >= 0) || draining || (q.size() > 0);
   endfunction

   int n_wr, irq_run, n_pulses;
   bit meas_irq;

   task automatic cycle();
      @(posedge clock);
      model_edge();
      #1;
      check("vram_we", vram_we, e_we);
      if (e_we) begin
         check("vram_a", vram_a, e_a);
         check("vram_d", vram_d, e_d);
      end
      check("border", border, m_border);
      check("beeper", beeper, m_beeper);
      check("irq", irq, m_irq > 0);
      check("flash", flash, m_flash);
      check("cpu_wait", cpu_wait, q.size() == DEPTH);
      if (vram_we) n_wr++;
      if (meas_irq) begin
         if (irq) irq_run++;
         else if (irq_run > 0) begin
            check("irq_len", irq_run, IRQ_LEN);
            n_pulses++;
            irq_run = 0;
         end
      end
   endtask

   task automatic idle_n(input int n);
      repeat (n) cycle();
   endtask

   task automatic mw(input logic [15:0] a, input logic [7:0] d);
      cpu_mw = 1'b1; cpu_a = a; cpu_d = d;
      cycle();
      cpu_mw = 1'b0;
   endtask

   task automatic io(input logic [15:0] a, input logic [7:0] d);
      cpu_iow = 1'b1; cpu_a = a; cpu_d = d;
      cycle();
      cpu_iow = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 8000 && busy(); i++) cycle();
      check("drain_timeout", busy(), 0);
   endtask

   initial begin
      reset = 1'b1; cpu_mw = 1'b0; cpu_iow = 1'b0; cpu_a = 16'h0; cpu_d = 8'h0; vs = 1'b1;
      meas_irq = 0; irq_run = 0; n_pulses = 0; n_wr = 0;
      idle_n(3);
      check("rst_vram_a", vram_a, 13'h0);
      check("rst_vram_d", vram_d, 8'h0);
      reset = 1'b0;
      idle_n(2);

      // Two back-to-back writes, then two out-of-range addresses
      mw(16'h4000, 8'hAA);
      mw(16'h5AFF, 8'h55);
      check("wr0_a", vram_a, 13'h0000);
      check("wr0_d", vram_d, 8'hAA);
      cycle();
      check("wr1_we", vram_we, 1);
      check("wr1_a", vram_a, 13'h1AFF);
      check("wr1_d", vram_d, 8'h55);
      n_wr = 0;
      mw(16'h5B00, 8'h11);
      mw(16'h3FFF, 8'h22);
      idle_n(3);
      check("oor_writes", n_wr, 0);

      // Port register, full and partial decode
      io(16'h00FE, 8'h15);
      check("port_border", border, 3'b101);
      check("port_beeper", beeper, 1);
      io(16'h12FE, 8'h02);
      check("port_border2", border, 3'b010);
      check("port_beeper2", beeper, 0);
      io(16'h12FE, 8'h15);
      check("port_border3", border, 3'b101);

      // Fill ordering: two queued writes drain first, second request ignored
      io(16'h00FD, 8'h47);
      n_wr = 0;
      mw(16'h4123, 8'hC1);
      mw(16'h4124, 8'hC2);
      io(16'h00FC, 8'h01);
      idle_n(100);
      io(16'h00FC, 8'h01);
      wait_idle();
      check("fill_last_a", vram_a, 13'h1AFF);
      check("fill_last_d", vram_d, 8'h47);
      idle_n(2);
      check("fill_writes", n_wr, 2 + 6912);

      // FIFO full behind a fill
      io(16'h00FC, 8'h01);
      for (int i = 0; i < 5; i++) begin
         mw(16'(16'h4200 + i), 8'(8'hD0 + i));
         if (i == 3) check("wait_after4", cpu_wait, 1);
      end
      check("wait_after5", cpu_wait, 1);
      wait_idle();
      idle_n(2);
      check("wait_clear", cpu_wait, 0);

      // Reset in the middle of the pixel fill with a non-empty FIFO
      io(16'h00FC, 8'h01);
      mw(16'h4300, 8'h01);
      mw(16'h4301, 8'h02);
      idle_n(255);
      check("pre_rst_a", vram_a, 13'h0100);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rst_fill_we", vram_we, 0);
      check("rst_fill_wait", cpu_wait, 0);
      n_wr = 0;
      mw(16'h4001, 8'h3C);
      check("post_rst_we0", vram_we, 0);
      cycle();
      check("post_rst_we1", vram_we, 1);
      check("post_rst_a", vram_a, 13'h0001);
      check("post_rst_d", vram_d, 8'h3C);
      idle_n(5);
      check("post_rst_writes", n_wr, 1);

      // 32 frames
      meas_irq = 1; irq_run = 0; n_pulses = 0;
      for (int f = 1; f <= 32; f++) begin
         vs = 1'b0;
         idle_n(3);
         vs = 1'b1;
         idle_n(40);
         if (f == 15) check("flash15", flash, 0);
         if (f == 16) check("flash16", flash, 1);
         if (f == 32) check("flash32", flash, 0);
      end
      meas_irq = 0;
      check("irq_pulses", n_pulses, 32);

      // Randomized traffic
      begin
         int fills = 0;
         for (int i = 0; i < 3000; i++) begin
            int r;
            int p;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 29) == 0) vs = ~vs;
            if (r < 40) begin
               cpu_mw = 1'b1;
               if ($urandom_range(0, 3) == 0) cpu_a = 16'($urandom);
               else cpu_a = 16'(16'h4000 + $urandom_range(0, 6911));
               cpu_d = 8'($urandom);
            end else if (r < 50) begin
               cpu_iow = 1'b1;
               cpu_d   = 8'($urandom);
               p = $urandom_range(0, 3);
               case (p)
                  0: cpu_a = {8'($urandom), 8'hFE};
                  1: cpu_a = {8'($urandom), 8'hFD};
                  2: begin
                     cpu_a = {8'($urandom), 8'hFC};
                     if (fills < 2 && $urandom_range(0, 3) == 0) begin
                        cpu_d[0] = 1'b1;
                        fills++;
                     end else cpu_d[0] = 1'b0;
                  end
                  default: cpu_a = {8'($urandom), 8'h10};
               endcase
            end
            cycle();
            cpu_mw = 1'b0;
            cpu_iow = 1'b0;
         end
         wait_idle();
         idle_n(40);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
